// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised operand register file.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic addr_valid(input int addr, input int depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks ptr over every entry, one per cycle, after reset or on clr_req.
// busy is high from the reset/request edge until the edge that clears entry DEPTH-1.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        if (state_q == ST_IDLE) begin
            if (clr_req) begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        end else begin
            // ptr holds at the last entry instead of wrapping
            if (ptr_q == LAST) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // The reset edge itself leaves storage untouched
    assign clr_we   = (state_q == ST_CLEAR) && !rst;
    assign clr_addr = ptr_q;
    assign busy     = busy_q;

endmodule

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file, two registered read ports with write-first bypass,
// optional hardwired zero entry, sequential clear after reset or on request.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rw,
    input  logic [WIDTH-1:0]  dw,
    input  logic              rwe,
    input  logic              clr_req,
    output logic [WIDTH-1:0]  crs,
    output logic [WIDTH-1:0]  crt,
    output logic              busy
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  crs_q, crs_d, crt_q, crt_d;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request in IDLE takes precedence over a same-cycle write
    assign wr_acc = !rst && !busy && rwe && !clr_req
                 && addr_valid(int'(rw), DEPTH)
                 && !(ZERO_REG != 0 && rw == '0);

    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end else if (wr_acc) begin
            mem_d[rw] = dw;
        end
    end

    always_comb begin
        crs_d = '0;
        crt_d = '0;
        if (!busy && addr_valid(int'(rs), DEPTH) && !(ZERO_REG != 0 && rs == '0)) begin
            crs_d = (wr_acc && rw == rs) ? dw : mem_q[rs];
        end
        if (!busy && addr_valid(int'(rt), DEPTH) && !(ZERO_REG != 0 && rt == '0)) begin
            crt_d = (wr_acc && rw == rt) ? dw : mem_q[rt];
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crs_q <= '0;
            crt_q <= '0;
        end else begin
            crs_q <= crs_d;
            crt_q <= crt_d;
        end
    end

    assign crs = crs_q;
    assign crt = crt_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three instances (4x4, 4x4 with zero register, 6x4).
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-entry instances share stimulus
    logic       rst, rwe, clr_req;
    logic [1:0] rs, rt, rw;
    logic [3:0] dw;
    logic [3:0] crs0, crt0, crs1, crt1;
    logic       busy0, busy1;

    // 6-entry instance
    logic       rst2, rwe2, clr2;
    logic [2:0] rs2, rt2, rw2;
    logic [3:0] dw2, crs2, crt2;
    logic       busy2;

    regfile_param #(.WIDTH(4), .DEPTH(4), .ZERO_REG(0)) u0 (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rw(rw), .dw(dw), .rwe(rwe),
        .clr_req(clr_req), .crs(crs0), .crt(crt0), .busy(busy0));

    regfile_param #(.WIDTH(4), .DEPTH(4), .ZERO_REG(1)) u1 (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rw(rw), .dw(dw), .rwe(rwe),
        .clr_req(clr_req), .crs(crs1), .crt(crt1), .busy(busy1));

    regfile_param #(.WIDTH(4), .DEPTH(6), .ZERO_REG(0)) u2 (
        .clk(clk), .rst(rst2), .rs(rs2), .rt(rt2), .rw(rw2), .dw(dw2), .rwe(rwe2),
        .clr_req(clr2), .crs(crs2), .crt(crt2), .busy(busy2));

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] crs;
        logic [3:0] crt;
    } exp_t;

    typedef struct {
        logic       rwe;
        logic [1:0] rw;
        logic [3:0] dw;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [3:0] c0s, c0t, c1s, c1t;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int dut, input logic [3:0] s, input logic [3:0] t);
        exp_t e;
        e.name = name; e.dut = dut; e.crs = s; e.crt = t;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [3:0] as, at;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin as = crs0; at = crt0; end
                1:       begin as = crs1; at = crt1; end
                default: begin as = crs2; at = crt2; end
            endcase
            check({e.name, "_crs"}, 32'(as), 32'(e.crs));
            check({e.name, "_crt"}, 32'(at), 32'(e.crt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              rwe rw  dw    rs  rt   u0 crs/crt  u1 crs/crt
        tbl[0] = '{1'b0, 2'd0, 4'h0, 2'd0, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1] = '{1'b0, 2'd0, 4'h0, 2'd2, 2'd3, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2] = '{1'b1, 2'd2, 4'h5, 2'd0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[3] = '{1'b0, 2'd0, 4'h0, 2'd1, 2'd2, 4'h0, 4'h5, 4'h0, 4'h5};
        tbl[4] = '{1'b1, 2'd3, 4'hA, 2'd3, 2'd2, 4'hA, 4'h5, 4'hA, 4'h5};
        tbl[5] = '{1'b0, 2'd0, 4'h0, 2'd3, 2'd3, 4'hA, 4'hA, 4'hA, 4'hA};
        tbl[6] = '{1'b1, 2'd0, 4'hF, 2'd0, 2'd1, 4'hF, 4'h0, 4'h0, 4'h0};
        tbl[7] = '{1'b1, 2'd1, 4'hF, 2'd0, 2'd1, 4'hF, 4'hF, 4'h0, 4'hF};
        tbl[8] = '{1'b1, 2'd3, 4'h6, 2'd3, 2'd0, 4'h6, 4'hF, 4'h6, 4'h0};
        tbl[9] = '{1'b0, 2'd0, 4'h0, 2'd3, 2'd2, 4'h6, 4'h5, 4'h6, 4'h5};

        rst = 1'b1; rwe = 1'b0; clr_req = 1'b0; rs = '0; rt = '0; rw = '0; dw = '0;
        rst2 = 1'b1; rwe2 = 1'b0; clr2 = 1'b0; rs2 = '0; rt2 = '0; rw2 = '0; dw2 = '0;
        step();
        check("rst_crs", 32'(crs0), 32'h0);
        check("rst_crt", 32'(crt0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h1);

        // Release reset and measure busy length on the 4-entry instances
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20 && busy0; k++) begin
            check("rclr_crs", 32'(crs0), 32'h0);
            check("rclr_crt", 32'(crt0), 32'h0);
            cnt++;
            step();
        end
        check("rst_busy_len", 32'(cnt), 32'd4);
        check("rst_busy1_done", 32'(busy1), 32'h0);

        for (int i = 0; i < 10; i++) begin
            rwe = tbl[i].rwe; rw = tbl[i].rw; dw = tbl[i].dw;
            rs = tbl[i].rs; rt = tbl[i].rt;
            push($sformatf("vec%0d_u0", i), 0, tbl[i].c0s, tbl[i].c0t);
            push($sformatf("vec%0d_u1", i), 1, tbl[i].c1s, tbl[i].c1t);
            step();
            drain();
        end

        // Clear request with a same-cycle write: write dropped, old data read
        clr_req = 1'b1; rwe = 1'b1; rw = 2'd1; dw = 4'h7; rs = 2'd1; rt = 2'd2;
        push("clr_first_u0", 0, 4'hF, 4'h5);
        push("clr_first_u1", 1, 4'hF, 4'h5);
        step();
        drain();
        check("clr_busy_start", 32'(busy0), 32'h1);

        // Writes to entry 0 during the clear must not survive it
        clr_req = 1'b0; rwe = 1'b1; rw = 2'd0; dw = 4'h9;
        cnt = 1;
        for (int k = 0; k < 20 && busy0; k++) begin
            clr_req = (k == 1);
            step();
            check("clr_rd_crs", 32'(crs0), 32'h0);
            check("clr_rd_crt", 32'(crt0), 32'h0);
            if (busy0) cnt++;
        end
        check("clr_busy_len", 32'(cnt), 32'd4);
        clr_req = 1'b0; rwe = 1'b0;

        rs = 2'd0; rt = 2'd1;
        push("post_clr_a_u0", 0, 4'h0, 4'h0);
        push("post_clr_a_u1", 1, 4'h0, 4'h0);
        step();
        drain();
        rs = 2'd2; rt = 2'd3;
        push("post_clr_b_u0", 0, 4'h0, 4'h0);
        step();
        drain();

        // 6-entry instance: reset re-asserted on the 3rd clear cycle
        rst2 = 1'b0;
        step();
        step();
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30 && busy2; k++) begin
            cnt++;
            step();
        end
        check("d6_busy_len", 32'(cnt), 32'd6);

        rwe2 = 1'b1; rw2 = 3'd5; dw2 = 4'hC; rs2 = 3'd5; rt2 = 3'd7;
        push("d6_wr5", 2, 4'hC, 4'h0);
        step();
        drain();
        rwe2 = 1'b1; rw2 = 3'd7; dw2 = 4'h3; rs2 = 3'd7; rt2 = 3'd6;
        push("d6_wr7", 2, 4'h0, 4'h0);
        step();
        drain();
        rwe2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs2 = 3'(2 * i); rt2 = 3'(2 * i + 1);
            push($sformatf("d6_rd%0d", i), 2, 4'h0, (i == 2) ? 4'hC : 4'h0);
            step();
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the fixed 4x4 register file: DEPTH entries of WIDTH bits, with two read ports (rs/rt) and one write port (rw/dw/rwe).
- Adds registered read outputs with write-to-read bypass, an optional hardwired zero register, and a sequential clear engine (one entry per cycle) that runs after reset or on request.
- Sits in the datapath as the CPU operand register file.

Parameters:
- WIDTH, 4: data width in bits.
- DEPTH, 4: number of registers, >=2; need not be a power of two.
- ZERO_REG, 0: 1 = entry 0 always reads 0 and writes to it are discarded.
- ADDR_W, $clog2(DEPTH): address width (derived; do not override).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs  in  ADDR_W  read address A.
- rt  in  ADDR_W  read address B.
- rw  in  ADDR_W  write address.
- dw  in  WIDTH  write data.
- rwe  in  1  write enable.
- clr_req  in  1  request to clear all registers (single-cycle pulse or level).
- crs  out  WIDTH  registered contents for rs.
- crt  out  WIDTH  registered contents for rt.
- busy  out  1  clear sequence in progress; writes ignored, reads return 0.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset (rst=1 at an edge):
  - crs=0, crt=0, busy=1, state=CLEAR, clear pointer ptr=0.
  - Storage is not touched on that edge.
- Clear state machine, states IDLE and CLEAR:
  - In CLEAR, each edge with rst=0: mem[ptr]<=0, ptr<=ptr+1.
  - At ptr==DEPTH-1: state<=IDLE, busy<=0 on that same edge.
  - Result: busy stays high exactly DEPTH cycles after rst drops.
- IDLE with clr_req=1: state<=CLEAR, ptr<=0, busy<=1 on the next edge.
  - A write presented in that same cycle is dropped; clear wins.
- clr_req while in CLEAR is ignored; the sequence does not restart.
- rst asserted mid-clear restarts the sequence from ptr=0.
- Write: mem[rw]<=dw at the edge when state==IDLE && rwe && !clr_req && rw<DEPTH && !(ZERO_REG && rw==0).
- Read, latency 1: crs/crt are registered from the addresses sampled at the same edge.
  - Default: crs<=mem[rs].
  - If a write is accepted at that edge and rw==rs, crs<=dw (bypass, write-first).
  - crt follows the same rule with rt.
- Read forcing to 0: rs/rt >= DEPTH, ZERO_REG && addr==0, or state==CLEAR.
- rs==rt is legal; both outputs get the same value.
- Widths: no arithmetic on data; ptr is ADDR_W bits and never wraps past DEPTH-1.

Decomposition:
- Shared package regfile_pkg:
  - State enum {ST_IDLE, ST_CLEAR}.
  - Function computing address-valid (addr<DEPTH).
- Sub-module regfile_clear_seq: state machine, ptr and busy. It outputs clr_we/clr_addr to the storage array in regfile_param.
- Read/bypass logic stays in the top module.

Test Plan:
- Reset then release: busy high exactly 4 cycles, then 0.
  - crs=crt=0 throughout.
  - All 4 entries read 0 afterwards.
- Basic write/read: write rw=2, dw=4'b0101; next cycle rs=1, rt=2 -> after one edge crs=0, crt=4'b0101.
- Bypass: rwe=1, rw=3, dw=4'hA, and rs=3 in the same cycle -> crs=4'hA at that edge. An old value of 3 must never appear.
- ZERO_REG=1: write rw=0, dw=4'hF -> rs=0 reads 0. A write to rw=1 with dw=4'hF reads back 4'hF.
- clr_req with rwe=1 (rw=1, dw=4'h7) in the same cycle:
  - Write dropped; busy high 4 cycles.
  - Reads during busy are 0; rwe during busy is ignored.
  - clr_req during CLEAR does not extend busy.
- DEPTH=6, with rst re-asserted at the 3rd clear cycle:
  - busy then lasts 6 cycles from release.
  - rs=7 reads 0; a write to rw=7 changes no entry.
